cv32e40s_csr_integrity_monitor: RTL and testbench
=================================================

// Module: cv32e40s_csr_integrity_monitor
// PURPOSE
//   Read-side consumer of the shadowed (hardened) CSR array. Samples the rd_error outputs of NUM_CSR
//   shadowed CSRs, latches sticky per-CSR status, records the first failing index and counts fault events.
//   Raises a level alert that is held until acknowledged by the alert handler.
//   Sits beside cs_registers; its alert feeds the core's major-alert aggregation.
// PARAMETERS
//   NUM_CSR     8   number of monitored shadowed CSRs (1..32)
//   CNT_WIDTH   8   width of saturating fault-event counter
//   IDX_WIDTH   $clog2(NUM_CSR) (min 1)  width of first-failure index (derived, not overridable)
// PORTS
//   clk            in   1          core clock
//   rst_n          in   1          reset, asynchronous, active-low
//   csr_err_i      in   NUM_CSR    rd_error of each shadowed CSR (bit i = CSR i)
//   mon_en_i       in   1          1: monitoring active; 0: inputs ignored, state held
//   clear_i        in   1          single-cycle pulse: clear status, index, counter; return to IDLE
//   alert_ack_i    in   1          alert handler acknowledge
//   alert_o        out  1          fault alert, held high until acknowledged
//   err_status_o   out  NUM_CSR    sticky per-CSR error flags
//   first_valid_o  out  1          first_idx_o is valid
//   first_idx_o    out  IDX_WIDTH  index of first CSR found faulty since last clear
//   err_cnt_o      out  CNT_WIDTH  saturating count of fault events since last clear
// BEHAVIOUR
//   Reset: alert_o=0, err_status_o=0, first_valid_o=0, first_idx_o=0, err_cnt_o=0, err_prev=0, state IDLE.
//   All outputs are registered. Input sampled at edge N is visible on outputs after edge N (1-cycle latency).
//   Event detect: new_err = csr_err_i & ~err_prev & {NUM_CSR{mon_en_i}}; err_prev <= csr_err_i every cycle.
//     A persistent fault counts once. A fault that deasserts and reasserts counts again.
//   err_status_o <= err_status_o | new_err. Sticky until clear_i.
//   err_cnt_o: += popcount(new_err), saturating at all-ones. Never wraps.
//   first_idx_o: on the first cycle with new_err!=0 while first_valid_o==0, capture the lowest set index
//     and set first_valid_o. Later events do not update it.
//   FSM (state enum in pkg):
//     IDLE:   new_err!=0                 -> ALERT (alert_o=1 next cycle)
//     ALERT:  alert_o=1; alert_ack_i      -> LOGGED (alert_o=0 next cycle)
//     LOGGED: sticky state held; new_err!=0 -> ALERT again (re-alert); counter still updates
//     any:    clear_i                    -> IDLE
//   clear_i and new_err in the same cycle: clear is applied first, then the new event.
//     Result: status=new_err, cnt=popcount(new_err), first_idx=lowest new bit, state ALERT.
//   alert_ack_i in IDLE or LOGGED is ignored. An ack in the same cycle ALERT is entered is ignored.
//   mon_en_i=0: no new events, no state transitions except clear_i; err_prev still tracks inputs.
//     Faults already present when monitoring is enabled are therefore not reported.
//   Async reset mid-alert: everything returns to reset values immediately. No alert survives reset.
// STRUCTURE
//   cv32e40s_pkg: csr_mon_state_e {MON_IDLE, MON_ALERT, MON_LOGGED}.
//   Sub-module cv32e40s_csr_mon_prio_enc (NUM_CSR-bit lowest-index priority encoder + any-set flag)
//     computes the first index.
//   popcount and saturating add stay inline. All flops are plain async-reset flops; no shadow copy here.
// TESTING
//   Reset then idle with csr_err_i=0 for 100 cycles -> all outputs 0, state IDLE.
//   csr_err_i=8'h24 held 10 cycles -> err_status=8'h24, first_idx=2, err_cnt=2, alert_o=1 until
//     alert_ack_i; then alert_o=0 on the cycle after ack.
//   CSR 5 toggles 0->1 300 times, CNT_WIDTH=8 -> err_cnt_o saturates at 255 and stays.
//   In LOGGED, csr_err_i bit 7 rises -> alert_o re-asserts, first_idx stays at its old value,
//     err_status bit 7 set.
//   clear_i coincident with bit 0 rising -> err_status=8'h01, cnt=1, first_idx=0, alert_o=1 next cycle.
//   mon_en_i=0 while bit 3 rises, then mon_en_i=1 -> no event. rst_n pulsed low while in ALERT
//     -> alert_o=0 asynchronously.

Source files
------------

// File: rtl/cv32e40s_pkg.sv
// Shared types for the CSR integrity monitor.
// Holds the monitor FSM state encoding and the popcount result width.
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_ALERT,
        MON_LOGGED
    } csr_mon_state_e;

    // Wide enough to count up to 32 simultaneous new faults.
    localparam int unsigned CSR_MON_POP_W = 6;

endpackage

// File: rtl/cv32e40s_csr_mon_prio_enc.sv
// Lowest-index priority encoder with an any-set flag.
// Ports: req (N request bits), any (some bit set), idx (lowest set index, 0 if none).
module cv32e40s_csr_mon_prio_enc #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cv32e40s_csr_integrity_monitor.sv
// Watches shadowed-CSR rd_error lines, keeps sticky status, first index, fault count and an acked alert.
// Ports: clk, rst_n, csr_err_i, mon_en_i, clear_i, alert_ack_i -> alert_o, err_status_o, first_valid_o, first_idx_o, err_cnt_o.
module cv32e40s_csr_integrity_monitor
    import cv32e40s_pkg::*;
#(
    parameter  int unsigned NUM_CSR   = 8,
    parameter  int unsigned CNT_WIDTH = 8,
    localparam int unsigned IDX_WIDTH = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CSR-1:0]   csr_err_i,
    input  logic                 mon_en_i,
    input  logic                 clear_i,
    input  logic                 alert_ack_i,
    output logic                 alert_o,
    output logic [NUM_CSR-1:0]   err_status_o,
    output logic                 first_valid_o,
    output logic [IDX_WIDTH-1:0] first_idx_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    csr_mon_state_e state_q, state_d, state_base;

    logic [NUM_CSR-1:0]       err_prev;
    logic [NUM_CSR-1:0]       status_q, status_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d, cnt_base;
    logic                     fv_q, fv_d, fv_base;
    logic [IDX_WIDTH-1:0]     idx_q, idx_d, idx_base;
    logic [NUM_CSR-1:0]       new_err;
    logic                     any_new;
    logic [IDX_WIDTH-1:0]     low_idx;
    logic [CSR_MON_POP_W-1:0] pop;
    logic [31:0]              sum;

    // Rising edges only: a fault held high counts once.
    assign new_err = csr_err_i & ~err_prev & {NUM_CSR{mon_en_i}};

    cv32e40s_csr_mon_prio_enc #(
        .N  (NUM_CSR),
        .IW (IDX_WIDTH)
    ) u_prio_enc (
        .req (new_err),
        .any (any_new),
        .idx (low_idx)
    );

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(NUM_CSR); i++) begin
            pop = pop + CSR_MON_POP_W'(new_err[i]);
        end
    end

    // A clear in the same cycle wipes old state first; the new event then lands on clean state.
    always_comb begin
        status_d   = (clear_i ? '0 : status_q) | new_err;
        cnt_base   = clear_i ? '0 : cnt_q;
        fv_base    = clear_i ? 1'b0 : fv_q;
        idx_base   = clear_i ? '0 : idx_q;
        state_base = clear_i ? MON_IDLE : state_q;

        sum   = 32'(cnt_base) + 32'(pop);
        cnt_d = (sum > 32'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];

        fv_d  = fv_base | any_new;
        idx_d = (!fv_base && any_new) ? low_idx : idx_base;
    end

    always_comb begin
        state_d = state_base;
        if (mon_en_i) begin
            case (state_base)
                MON_IDLE, MON_LOGGED: begin
                    if (any_new) begin
                        state_d = MON_ALERT;
                    end
                end
                MON_ALERT: begin
                    // A fresh fault alongside the ack keeps the alert up.
                    if (!any_new && alert_ack_i) begin
                        state_d = MON_LOGGED;
                    end
                end
                default: state_d = MON_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MON_IDLE;
            err_prev <= '0;
            status_q <= '0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            err_prev <= csr_err_i;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            fv_q     <= fv_d;
            idx_q    <= idx_d;
        end
    end

    assign alert_o       = (state_q == MON_ALERT);
    assign err_status_o  = status_q;
    assign err_cnt_o     = cnt_q;
    assign first_valid_o = fv_q;
    assign first_idx_o   = idx_q;

endmodule

// File: tb/tb_cv32e40s_csr_integrity_monitor.sv
// Randomized and directed bench for the CSR integrity monitor.
// Compares the DUT every cycle with an event-level model of the monitor.
module tb_cv32e40s_csr_integrity_monitor;

    localparam int N  = 8;
    localparam int CW = 8;
    localparam int IW = 3;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  csr_err = '0;
    logic          mon_en = 1'b0;
    logic          clear = 1'b0;
    logic          ack = 1'b0;
    logic          alert;
    logic [N-1:0]  status;
    logic          first_valid;
    logic [IW-1:0] first_idx;
    logic [CW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: an alert flag is enough, since IDLE and LOGGED react identically.
    logic [N-1:0] m_prev;
    logic [N-1:0] m_status;
    int           m_cnt;
    bit           m_fv;
    int           m_idx;
    bit           m_alert;

    cv32e40s_csr_integrity_monitor #(
        .NUM_CSR   (N),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_err_i     (csr_err),
        .mon_en_i      (mon_en),
        .clear_i       (clear),
        .alert_ack_i   (ack),
        .alert_o       (alert),
        .err_status_o  (status),
        .first_valid_o (first_valid),
        .first_idx_o   (first_idx),
        .err_cnt_o     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_prev   = '0;
        m_status = '0;
        m_cnt    = 0;
        m_fv     = 1'b0;
        m_idx    = 0;
        m_alert  = 1'b0;
    endtask

    initial m_reset();

    always @(negedge rst_n) m_reset();

    always @(posedge clk) begin
        logic [N-1:0] nw;
        int           lo;
        if (rst_n) begin
            nw = mon_en ? (csr_err & ~m_prev) : '0;
            m_prev = csr_err;
            if (clear) begin
                m_status = '0;
                m_cnt    = 0;
                m_fv     = 1'b0;
                m_idx    = 0;
                m_alert  = 1'b0;
            end
            m_status = m_status | nw;
            m_cnt = m_cnt + $countones(nw);
            if (m_cnt > CMAX) m_cnt = CMAX;
            lo = 0;
            for (int i = N - 1; i >= 0; i--) if (nw[i]) lo = i;
            if (!m_fv && nw != 0) begin
                m_fv  = 1'b1;
                m_idx = lo;
            end
            if (mon_en) begin
                if (nw != 0) m_alert = 1'b1;
                else if (m_alert && ack) m_alert = 1'b0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            cmp("model_alert", int'(alert), int'(m_alert));
            cmp("model_status", int'(status), int'(m_status));
            cmp("model_cnt", int'(err_cnt), m_cnt);
            cmp("model_fv", int'(first_valid), int'(m_fv));
            cmp("model_idx", int'(first_idx), m_idx);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] flip;

        repeat (3) tick();
        rst_n = 1'b1;
        cmp("reset_alert", int'(alert), 0);
        cmp("reset_status", int'(status), 0);
        cmp("reset_cnt", int'(err_cnt), 0);
        cmp("reset_fv", int'(first_valid), 0);

        mon_en = 1'b1;
        chk_en = 1'b1;
        repeat (100) tick();
        cmp("idle_alert", int'(alert), 0);
        cmp("idle_status", int'(status), 0);
        cmp("idle_cnt", int'(err_cnt), 0);

        csr_err = 8'h24;
        repeat (10) tick();
        cmp("h24_status", int'(status), 'h24);
        cmp("h24_idx", int'(first_idx), 2);
        cmp("h24_fv", int'(first_valid), 1);
        cmp("h24_cnt", int'(err_cnt), 2);
        cmp("h24_alert", int'(alert), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        cmp("ack_alert", int'(alert), 0);

        csr_err = 8'ha4;
        tick();
        cmp("realert_alert", int'(alert), 1);
        cmp("realert_idx", int'(first_idx), 2);
        cmp("realert_status", int'(status), 'ha4);
        cmp("realert_cnt", int'(err_cnt), 3);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        csr_err = 8'ha5;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cmp("clrev_status", int'(status), 'h01);
        cmp("clrev_cnt", int'(err_cnt), 1);
        cmp("clrev_idx", int'(first_idx), 0);
        cmp("clrev_alert", int'(alert), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        mon_en = 1'b0;
        csr_err = 8'had;
        repeat (2) tick();
        mon_en = 1'b1;
        repeat (2) tick();
        cmp("dis_status", int'(status), 'h01);
        cmp("dis_cnt", int'(err_cnt), 1);
        cmp("dis_alert", int'(alert), 0);

        clear = 1'b1;
        csr_err = '0;
        tick();
        clear = 1'b0;
        repeat (300) begin
            csr_err = 8'h20;
            tick();
            csr_err = 8'h00;
            tick();
        end
        cmp("sat_cnt", int'(err_cnt), 255);
        cmp("sat_status", int'(status), 'h20);
        cmp("sat_alert", int'(alert), 1);

        #1;
        rst_n = 1'b0;
        #1;
        cmp("arst_alert", int'(alert), 0);
        cmp("arst_cnt", int'(err_cnt), 0);
        cmp("arst_status", int'(status), 0);
        repeat (2) tick();
        rst_n = 1'b1;

        repeat (3000) begin
            flip = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) flip[i] = 1'b1;
            end
            csr_err = csr_err ^ flip;
            mon_en = ($urandom_range(7) != 0);
            clear = ($urandom_range(39) == 0);
            ack = ($urandom_range(2) == 0);
            tick();
        end
        clear = 1'b0;
        ack = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
